// File: rtl/channel_pkg.sv
// Shared definitions for the APU voice channels: default widths, LFSR seed,
// noise feedback-mode encoding and the length-counter lookup table.
// Ports: none (package only).
package channel_pkg;

  // Value loaded into every noise LFSR on reset and on all-zero recovery.
  localparam int LFSR_SEED = 1;

  // Default widths shared by the voices.
  localparam int DEF_LFSR_WIDTH   = 15;
  localparam int DEF_SHORT_TAP    = 6;
  localparam int DEF_PERIOD_WIDTH = 12;
  localparam int DEF_VOL_WIDTH    = 4;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_OUT_WIDTH    = 9;

  // Noise feedback mode: long uses tap 1, short (metallic) uses SHORT_TAP.
  typedef enum logic {
    MODE_LONG  = 1'b0,
    MODE_SHORT = 1'b1
  } noise_mode_e;

  // Length-counter lookup: 32 entries of 8 bits, entry 0 in the low byte.
  // Voices that load length from a 5-bit index use len_lookup().
  localparam int LEN_TABLE_SIZE = 32;
  localparam logic [8*LEN_TABLE_SIZE-1:0] LEN_TABLE = {
    8'd30,  8'd32,  8'd28, 8'd16,  8'd26, 8'd72, 8'd24, 8'd192,
    8'd22,  8'd96,  8'd20, 8'd48,  8'd18, 8'd24, 8'd16, 8'd12,
    8'd14,  8'd26,  8'd12, 8'd14,  8'd10, 8'd60, 8'd8,  8'd160,
    8'd6,   8'd80,  8'd4,  8'd40,  8'd2,  8'd20, 8'd254, 8'd10
  };

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    return LEN_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/channel_noise_gen_envelope_unit.sv
// Volume/decay envelope shared by noise and pulse voices.
// Ports: i_clk/i_rst_n, i_tick_stb (frame tick), i_start_stb (note restart),
//        i_period (divider reload), i_loop (wrap decay), o_decay (level).
module envelope_unit
  import channel_pkg::*;
#(
  parameter int VOL_WIDTH = DEF_VOL_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick_stb,
  input  logic                 i_start_stb,
  input  logic [VOL_WIDTH-1:0] i_period,
  input  logic                 i_loop,
  output logic [VOL_WIDTH-1:0] o_decay
);

  localparam logic [VOL_WIDTH-1:0] VOL_ONE = VOL_WIDTH'(1);

  logic                 start_q, start_d;
  logic [VOL_WIDTH-1:0] divider_q, divider_d;
  logic [VOL_WIDTH-1:0] decay_q, decay_d;

  always_comb begin
    start_d   = start_q;
    divider_d = divider_q;
    decay_d   = decay_q;
    // A restart coinciding with a tick wins; the flag is serviced on the
    // next tick so the full level is presented for a whole tick period.
    if (i_start_stb) begin
      start_d = 1'b1;
    end else if (i_tick_stb) begin
      if (start_q) begin
        start_d   = 1'b0;
        decay_d   = '1;
        divider_d = i_period;
      end else if (divider_q == '0) begin
        divider_d = i_period;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_ONE;
        end else if (i_loop) begin
          decay_d = '1;
        end
      end else begin
        divider_d = divider_q - VOL_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_q   <= 1'b0;
      divider_q <= '0;
      decay_q   <= '0;
    end else begin
      start_q   <= start_d;
      divider_q <= divider_d;
      decay_q   <= decay_d;
    end
  end

  assign o_decay = decay_q;

endmodule

// File: rtl/channel_noise_gen.sv
// Noise voice: programmable-period LFSR (long/short feedback), envelope and
// length counter, producing a registered unsigned amplitude sample.
// Ports: i_clk/i_rst_n; strobes i_tick_stb, i_note_stb, i_cfg_stb; config
//        i_mode, i_period, i_volume, i_const_vol, i_loop, i_length;
//        outputs o_output (sample), o_active (length != 0), o_frame_pulse.
module channel_noise_gen
  import channel_pkg::*;
#(
  parameter int LFSR_WIDTH   = DEF_LFSR_WIDTH,
  parameter int SHORT_TAP    = DEF_SHORT_TAP,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int VOL_WIDTH    = DEF_VOL_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick_stb,
  input  logic                    i_note_stb,
  input  logic                    i_cfg_stb,
  input  logic                    i_mode,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic [VOL_WIDTH-1:0]    i_volume,
  input  logic                    i_const_vol,
  input  logic                    i_loop,
  input  logic [LEN_WIDTH-1:0]    i_length,
  output logic [OUT_WIDTH-1:0]    o_output,
  output logic                    o_active,
  output logic                    o_frame_pulse
);

  localparam logic [LFSR_WIDTH-1:0]   SEED       = LFSR_WIDTH'(LFSR_SEED);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_ONE    = LEN_WIDTH'(1);

  // Latched configuration
  noise_mode_e             mode_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [VOL_WIDTH-1:0]    volume_q;
  logic                    const_vol_q;
  logic                    loop_q;

  // Timer / LFSR
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [LFSR_WIDTH-1:0]   sr_q, sr_d;
  logic                    step;
  logic                    tap_bit;
  logic                    fb;

  // Length counter
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    len_expire;

  // Envelope and output
  logic [VOL_WIDTH-1:0]    env_decay;
  logic [VOL_WIDTH-1:0]    level;
  logic [OUT_WIDTH-1:0]    out_q, out_d;
  logic                    active_q;
  logic                    frame_pulse_q;

  // ---------------------------------------------------------------------
  // Timer: the step fires on the cycle the counter sits at zero, so a
  // freshly reset block steps on its very first clock and period 0 steps
  // every clock. A new period is only picked up at reload.
  // ---------------------------------------------------------------------
  assign step = (timer_q == '0);

  always_comb begin
    timer_d = step ? period_q : (timer_q - PERIOD_ONE);
  end

  // ---------------------------------------------------------------------
  // LFSR: shift right, feedback into the MSB.
  // ---------------------------------------------------------------------
  assign tap_bit = (mode_q == MODE_SHORT) ? sr_q[SHORT_TAP] : sr_q[1];
  assign fb      = sr_q[0] ^ tap_bit;

  always_comb begin
    sr_d = sr_q;
    if (step) begin
      // All-zero is a lock-up state; recover to the seed if ever seen.
      if (sr_q == '0) begin
        sr_d = SEED;
      end else begin
        sr_d = {fb, sr_q[LFSR_WIDTH-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Length counter: a note load has priority over a same-cycle tick.
  // loop_q doubles as the length halt.
  // ---------------------------------------------------------------------
  always_comb begin
    len_d      = len_q;
    len_expire = 1'b0;
    if (i_note_stb) begin
      len_d = i_length;
    end else if (i_tick_stb && (len_q != '0) && !loop_q) begin
      len_d      = len_q - LEN_ONE;
      len_expire = (len_q == LEN_ONE);
    end
  end

  // ---------------------------------------------------------------------
  // Envelope. It sees the registered config, so a config write on the same
  // cycle as a tick only affects later ticks.
  // ---------------------------------------------------------------------
  envelope_unit #(
    .VOL_WIDTH (VOL_WIDTH)
  ) u_env (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_tick_stb  (i_tick_stb),
    .i_start_stb (i_note_stb),
    .i_period    (volume_q),
    .i_loop      (loop_q),
    .o_decay     (env_decay)
  );

  // ---------------------------------------------------------------------
  // Output sample: silent when the length is spent or the LFSR LSB is 1.
  // ---------------------------------------------------------------------
  assign level = const_vol_q ? volume_q : env_decay;

  always_comb begin
    out_d = '0;
    if ((len_q != '0) && !sr_q[0]) begin
      out_d = OUT_WIDTH'(level);
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q        <= MODE_LONG;
      period_q      <= '0;
      volume_q      <= '0;
      const_vol_q   <= 1'b0;
      loop_q        <= 1'b0;
      timer_q       <= '0;
      sr_q          <= SEED;
      len_q         <= '0;
      out_q         <= '0;
      active_q      <= 1'b0;
      frame_pulse_q <= 1'b0;
    end else begin
      if (i_cfg_stb) begin
        mode_q      <= noise_mode_e'(i_mode);
        period_q    <= i_period;
        volume_q    <= i_volume;
        const_vol_q <= i_const_vol;
        loop_q      <= i_loop;
      end
      timer_q       <= timer_d;
      sr_q          <= sr_d;
      len_q         <= len_d;
      out_q         <= out_d;
      active_q      <= (len_q != '0);
      frame_pulse_q <= len_expire;
    end
  end

  assign o_output      = out_q;
  assign o_active      = active_q;
  assign o_frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_channel_noise_gen.sv
module tb_channel_noise_gen;

  localparam int LW  = 15;
  localparam int ST  = 6;
  localparam int PW  = 12;
  localparam int VW  = 4;
  localparam int LNW = 8;
  localparam int OW  = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick_stb = 1'b0;
  logic          note_stb = 1'b0;
  logic          cfg_stb = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] period = '0;
  logic [VW-1:0] volume = '0;
  logic          const_vol = 1'b0;
  logic          loop_en = 1'b0;
  logic [LNW-1:0] length = '0;
  logic [OW-1:0] o_output;
  logic          o_active;
  logic          o_frame_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_sr, m_timer, m_period, m_mode, m_vol, m_cv, m_loop;
  int m_len, m_decay, m_div, m_start, m_out, m_act, m_fp;

  // Scenario-1 recordings: [run][cycle]
  int rec_out [2][16];
  int rec_sr  [2][16];

  channel_noise_gen #(
    .LFSR_WIDTH(LW), .SHORT_TAP(ST), .PERIOD_WIDTH(PW),
    .VOL_WIDTH(VW), .LEN_WIDTH(LNW), .OUT_WIDTH(OW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_stb(tick_stb), .i_note_stb(note_stb),
    .i_cfg_stb(cfg_stb), .i_mode(mode), .i_period(period), .i_volume(volume),
    .i_const_vol(const_vol), .i_loop(loop_en), .i_length(length),
    .o_output(o_output), .o_active(o_active), .o_frame_pulse(o_frame_pulse)
  );

  always #5 clk = ~clk;

  // One LFSR step as arithmetic on an integer.
  function automatic int lfsr_next(input int s, input int tap);
    int fb;
    if (s == 0) return 1;
    fb = (s ^ (s >> tap)) & 1;
    return (s >> 1) | (fb << (LW - 1));
  endfunction

  function automatic int short_period();
    int s = 1;
    for (int n = 1; n <= 5000; n++) begin
      s = lfsr_next(s, ST);
      if (s == 1) return n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sr = 1; m_timer = 0; m_period = 0; m_mode = 0; m_vol = 0; m_cv = 0;
    m_loop = 0; m_len = 0; m_decay = 0; m_div = 0; m_start = 0;
    m_out = 0; m_act = 0; m_fp = 0;
  endtask

  // Advance one clock: evaluate the rules on the pre-edge state and inputs,
  // then commit after the edge. Strobes are one-cycle and cleared here.
  task automatic clk_cycle();
    int n_sr, n_timer, n_len, n_decay, n_div, n_start, n_out, n_act, n_fp;
    int n_mode, n_period, n_vol, n_cv, n_loop;
    bit stp;
    stp     = (m_timer == 0);
    n_timer = stp ? m_period : m_timer - 1;
    n_sr    = stp ? lfsr_next(m_sr, (m_mode != 0) ? ST : 1) : m_sr;
    n_mode  = cfg_stb ? int'(mode)      : m_mode;
    n_period= cfg_stb ? int'(period)    : m_period;
    n_vol   = cfg_stb ? int'(volume)    : m_vol;
    n_cv    = cfg_stb ? int'(const_vol) : m_cv;
    n_loop  = cfg_stb ? int'(loop_en)   : m_loop;
    n_len = m_len; n_fp = 0;
    if (note_stb) n_len = int'(length);
    else if (tick_stb && m_len != 0 && m_loop == 0) begin
      n_len = m_len - 1;
      n_fp  = (m_len == 1) ? 1 : 0;
    end
    n_decay = m_decay; n_div = m_div; n_start = m_start;
    if (note_stb) n_start = 1;
    else if (tick_stb) begin
      if (m_start != 0) begin n_decay = (1 << VW) - 1; n_div = m_vol; n_start = 0; end
      else if (m_div == 0) begin
        n_div = m_vol;
        if (m_decay > 0) n_decay = m_decay - 1;
        else if (m_loop != 0) n_decay = (1 << VW) - 1;
      end else n_div = m_div - 1;
    end
    n_out = (m_len == 0 || (m_sr & 1) == 1) ? 0 : ((m_cv != 0) ? m_vol : m_decay);
    n_act = (m_len != 0) ? 1 : 0;
    @(posedge clk);
    m_sr = n_sr; m_timer = n_timer; m_mode = n_mode; m_period = n_period;
    m_vol = n_vol; m_cv = n_cv; m_loop = n_loop; m_len = n_len; m_fp = n_fp;
    m_decay = n_decay; m_div = n_div; m_start = n_start; m_out = n_out; m_act = n_act;
    #1;
    tick_stb = 1'b0; note_stb = 1'b0; cfg_stb = 1'b0;
  endtask

  task automatic do_reset();
    tick_stb = 1'b0; note_stb = 1'b0; cfg_stb = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scenario 1: config + note on the first clock after reset release.
  task automatic scenario1(input int run);
    cfg_stb = 1'b1; mode = 1'b0; period = '0; volume = 4'd9; const_vol = 1'b1;
    loop_en = 1'b0; note_stb = 1'b1; length = 8'd10;
    for (int k = 0; k < 16; k++) begin
      clk_cycle();
      rec_out[run][k] = int'(o_output);
      rec_sr[run][k]  = int'(dut.sr_q);
      checks++;
      if (o_output !== OW'(m_out)) begin
        errors++;
        $display("FAIL s1_output run%0d cyc%0d: got %0d expected %0d", run, k, o_output, m_out);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_output !== '0) begin errors++; $display("FAIL reset_output: got %0d expected 0", o_output); end
    checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b expected 0", o_active); end
    checks++; if (o_frame_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b expected 0", o_frame_pulse); end
    checks++; if (int'(dut.sr_q) !== 1) begin errors++; $display("FAIL reset_sr: got %h expected 0001", dut.sr_q); end
  endtask

  task automatic test_scenario1();
    scenario1(0);
    checks++; if (rec_sr[0][0] !== 'h4000) begin errors++; $display("FAIL s1_sr_step1: got %h expected 4000", rec_sr[0][0]); end
    checks++; if (rec_sr[0][1] !== 'h2000) begin errors++; $display("FAIL s1_sr_step2: got %h expected 2000", rec_sr[0][1]); end
    checks++; if (rec_out[0][0] !== 0) begin errors++; $display("FAIL s1_out_first: got %0d expected 0", rec_out[0][0]); end
    checks++; if (rec_out[0][1] !== 9) begin errors++; $display("FAIL s1_out_second: got %0d expected 9", rec_out[0][1]); end
  endtask

  task automatic test_reset_mid();
    int mism = 0;
    repeat (5) clk_cycle();
    checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL mid_pre_active: got %0b expected 1", o_active); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_output !== '0) begin errors++; $display("FAIL mid_async_output: got %0d expected 0", o_output); end
    checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL mid_async_active: got %0b expected 0", o_active); end
    checks++; if (o_frame_pulse !== 1'b0) begin errors++; $display("FAIL mid_async_pulse: got %0b expected 0", o_frame_pulse); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scenario1(1);
    for (int k = 0; k < 16; k++)
      if (rec_out[1][k] != rec_out[0][k] || rec_sr[1][k] != rec_sr[0][k]) mism++;
    checks++; if (mism !== 0) begin errors++; $display("FAIL mid_replay: %0d differing cycles, expected 0", mism); end
  endtask

  task automatic test_long_period();
    int first_ret = 0;
    do_reset();
    for (int i = 1; i <= 32767; i++) begin
      clk_cycle();
      if (first_ret == 0 && int'(dut.sr_q) == 1) first_ret = i;
    end
    checks++; if (first_ret !== 32767) begin errors++; $display("FAIL long_period: returned at step %0d expected 32767", first_ret); end
    checks++; if (int'(dut.sr_q) !== m_sr) begin errors++; $display("FAIL long_final_sr: got %h expected %h", dut.sr_q, m_sr); end
  endtask

  task automatic test_short();
    int mism = 0, ret = 0, exp_p, prev;
    exp_p = short_period();
    do_reset();
    cfg_stb = 1'b1; mode = 1'b1; period = '0; volume = '0; const_vol = 1'b0; loop_en = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      clk_cycle();
      if (int'(dut.sr_q) != m_sr) mism++;
      if (ret == 0 && int'(dut.sr_q) == 1) ret = i;
    end
    checks++; if (mism !== 0) begin errors++; $display("FAIL short_bits: %0d mismatching steps expected 0", mism); end
    checks++; if (ret !== exp_p) begin errors++; $display("FAIL short_period: got %0d expected %0d", ret, exp_p); end
    // Switch to long mode: the write edge still steps with short feedback.
    prev = int'(dut.sr_q);
    cfg_stb = 1'b1; mode = 1'b0;
    clk_cycle();
    checks++; if (int'(dut.sr_q) !== lfsr_next(prev, ST)) begin errors++; $display("FAIL switch_old_tap: got %h expected %h", dut.sr_q, lfsr_next(prev, ST)); end
    prev = int'(dut.sr_q);
    clk_cycle();
    checks++; if (int'(dut.sr_q) !== lfsr_next(prev, 1)) begin errors++; $display("FAIL switch_new_tap: got %h expected %h", dut.sr_q, lfsr_next(prev, 1)); end
  endtask

  task automatic test_envelope();
    int exp_d;
    do_reset();
    cfg_stb = 1'b1; mode = 1'b0; period = '0; volume = 4'd2; const_vol = 1'b0; loop_en = 1'b0;
    note_stb = 1'b1; length = 8'd255;
    clk_cycle();
    for (int k = 1; k <= 52; k++) begin
      tick_stb = 1'b1;
      clk_cycle();
      exp_d = 15 - (k - 1) / 3;
      if (exp_d < 0) exp_d = 0;
      checks++; if (int'(dut.env_decay) !== exp_d) begin errors++; $display("FAIL env_decay tick%0d: got %0d expected %0d", k, dut.env_decay, exp_d); end
      clk_cycle();
      checks++; if (o_output !== OW'(m_out)) begin errors++; $display("FAIL env_output tick%0d: got %0d expected %0d", k, o_output, m_out); end
    end
    cfg_stb = 1'b1; loop_en = 1'b1; note_stb = 1'b1;
    clk_cycle();
    for (int k = 1; k <= 60; k++) begin
      tick_stb = 1'b1;
      clk_cycle();
      exp_d = 15 - ((k - 1) / 3) % 16;
      checks++; if (int'(dut.env_decay) !== exp_d) begin errors++; $display("FAIL env_loop tick%0d: got %0d expected %0d", k, dut.env_decay, exp_d); end
      clk_cycle();
    end
  endtask

  task automatic test_length();
    int ticks = 0, pulses = 0, pulse_at = -1, nz = 0;
    bit was_tick;
    do_reset();
    cfg_stb = 1'b1; mode = 1'b0; period = '0; volume = 4'd9; const_vol = 1'b1; loop_en = 1'b0;
    note_stb = 1'b1; length = 8'd3;
    clk_cycle();
    for (int c = 0; c < 24; c++) begin
      was_tick = (c % 4 == 3);
      tick_stb = was_tick;
      clk_cycle();
      if (was_tick) ticks++;
      if (o_frame_pulse === 1'b1) begin
        pulses++;
        if (was_tick) pulse_at = ticks;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL len_pulse_count: got %0d expected 1", pulses); end
    checks++; if (pulse_at !== 3) begin errors++; $display("FAIL len_pulse_timing: after tick %0d expected 3", pulse_at); end
    checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL len_inactive: got %0b expected 0", o_active); end
    for (int c = 0; c < 16; c++) begin
      clk_cycle();
      if (o_output !== '0) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL len_silent: %0d nonzero samples expected 0", nz); end
    note_stb = 1'b1; tick_stb = 1'b1; length = 8'd5;
    clk_cycle();
    checks++; if (int'(dut.len_q) !== 5) begin errors++; $display("FAIL note_tick_len: got %0d expected 5", dut.len_q); end
    tick_stb = 1'b1;
    clk_cycle();
    checks++; if (int'(dut.len_q) !== 4) begin errors++; $display("FAIL tick_after_note: got %0d expected 4", dut.len_q); end
    checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL note_active: got %0b expected 1", o_active); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cfg_stb  = ($urandom_range(0, 15) == 0);
      mode     = 1'($urandom);
      period   = PW'($urandom_range(0, 3));
      volume   = VW'($urandom);
      const_vol= 1'($urandom);
      loop_en  = ($urandom_range(0, 3) == 0);
      note_stb = ($urandom_range(0, 31) == 0);
      length   = LNW'($urandom_range(0, 12));
      tick_stb = ($urandom_range(0, 3) == 0);
      clk_cycle();
      checks++; if (o_output !== OW'(m_out)) begin errors++; $display("FAIL rnd_output cyc%0d: got %0d expected %0d", c, o_output, m_out); end
      checks++; if (o_active !== 1'(m_act)) begin errors++; $display("FAIL rnd_active cyc%0d: got %0b expected %0d", c, o_active, m_act); end
      checks++; if (o_frame_pulse !== 1'(m_fp)) begin errors++; $display("FAIL rnd_pulse cyc%0d: got %0b expected %0d", c, o_frame_pulse, m_fp); end
      checks++; if (int'(dut.sr_q) !== m_sr) begin errors++; $display("FAIL rnd_sr cyc%0d: got %h expected %h", c, dut.sr_q, m_sr); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_scenario1();
    test_reset_mid();
    test_long_period();
    test_short();
    test_envelope();
    test_length();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
